// File: rtl/pi_gpio_rx.sv
// Raspberry Pi GPIO byte receiver: synchronizes strobe/data, captures one image frame, then waits for rearm.
// Optional idle-timeout abort in RECV is compiled in with PI_RX_TIMEOUT_EN.
module pi_gpio_rx #(
    parameter int FRAME_BYTES    = 1800,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        pi_clk,
    input  logic        rst,
    input  logic [7:0]  pi_data,
    input  logic        pi_strobe,
    input  logic        rearm,
    output logic [7:0]  gpio_pin,
    output logic        write_enable,
    output logic [10:0] byte_count,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} state_t;
    localparam logic [10:0] FRAME_LAST = 11'(FRAME_BYTES);

    logic [SYNC_STAGES-1:0] strobe_sync_r;
    logic [7:0]             data_sync_r [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] settle_r;
    logic                   strobe_prev_r;
    logic                   strobe_s;
    logic                   edge_s;
    logic                   expire_s;
    logic [10:0]            count_inc_s;
    logic                   last_s;
    state_t                 state_r;
    state_t                 state_next_s;

    logic [7:0]  gpio_pin_r,     gpio_pin_next_s;
    logic        write_enable_r, write_enable_next_s;
    logic [10:0] byte_count_r,   byte_count_next_s;
    logic        frame_done_r,   frame_done_next_s;
    logic        overrun_r,      overrun_next_s;

    // Until the chain has refilled after reset, the previous-strobe register is held high
    // so a strobe already high at reset release is not mistaken for a rising edge.
    assign strobe_s    = strobe_sync_r[SYNC_STAGES-1];
    assign edge_s      = strobe_s & ~strobe_prev_r & settle_r[SYNC_STAGES-1];
    assign count_inc_s = (byte_count_r == FRAME_LAST) ? byte_count_r : byte_count_r + 11'd1;
    assign last_s      = (count_inc_s == FRAME_LAST);

    // Synchronizer chains for the asynchronous Pi signals plus edge-detect history.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            strobe_sync_r <= '0;
            settle_r      <= '0;
            strobe_prev_r <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_r[i] <= 8'd0;
            end
        end else begin
            strobe_sync_r  <= {strobe_sync_r[SYNC_STAGES-2:0], pi_strobe};
            settle_r       <= {settle_r[SYNC_STAGES-2:0], 1'b1};
            strobe_prev_r  <= settle_r[SYNC_STAGES-1] ? strobe_s : 1'b1;
            data_sync_r[0] <= pi_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_r[i] <= data_sync_r[i-1];
            end
        end
    end

    // State register.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (edge_s) state_next_s = last_s ? DONE : RECV;
                else        state_next_s = IDLE;
            end
            RECV: begin
                if (edge_s)        state_next_s = last_s ? DONE : RECV;
                else if (expire_s) state_next_s = IDLE;
                else               state_next_s = RECV;
            end
            DONE: begin
                if (rearm) state_next_s = IDLE;
                else       state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output next-value logic; a rearm in DONE takes priority over a coincident edge.
    always_comb begin
        gpio_pin_next_s     = gpio_pin_r;
        write_enable_next_s = 1'b0;
        byte_count_next_s   = byte_count_r;
        frame_done_next_s   = 1'b0;
        overrun_next_s      = overrun_r;
        case (state_r)
            IDLE, RECV: begin
                if (edge_s) begin
                    gpio_pin_next_s     = data_sync_r[SYNC_STAGES-1];
                    write_enable_next_s = 1'b1;
                    byte_count_next_s   = count_inc_s;
                    frame_done_next_s   = last_s;
                end else if (expire_s) begin
                    byte_count_next_s   = 11'd0;
                end else begin
                    byte_count_next_s   = byte_count_r;
                end
            end
            DONE: begin
                if (rearm) begin
                    byte_count_next_s = 11'd0;
                    overrun_next_s    = 1'b0;
                end else if (edge_s) begin
                    overrun_next_s    = 1'b1;
                end else begin
                    overrun_next_s    = overrun_r;
                end
            end
            default: begin
                byte_count_next_s = 11'd0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            gpio_pin_r     <= 8'd0;
            write_enable_r <= 1'b0;
            byte_count_r   <= 11'd0;
            frame_done_r   <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            gpio_pin_r     <= gpio_pin_next_s;
            write_enable_r <= write_enable_next_s;
            byte_count_r   <= byte_count_next_s;
            frame_done_r   <= frame_done_next_s;
            overrun_r      <= overrun_next_s;
        end
    end

    assign gpio_pin     = gpio_pin_r;
    assign write_enable = write_enable_r;
    assign byte_count   = byte_count_r;
    assign frame_done   = frame_done_r;
    assign busy         = (state_r == RECV);
    assign overrun      = overrun_r;

`ifdef PI_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;

    assign expire_s = (state_r == RECV) && !edge_s &&
                      (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, restarted by every edge and held at zero outside RECV.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r != RECV) || edge_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Sticky abort flag, cleared only by a rearm from DONE.
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else if ((state_r == DONE) && rearm) begin
            timeout_err_r <= 1'b0;
        end else if (expire_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    // TIMEOUT_CYCLES has no role when the timeout is compiled out.
    assign expire_s    = 1'b0;
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
endmodule

// File: doc/pi_gpio_rx.md
PI_GPIO_RX -- requirements
Module: pi_gpio_rx

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 1800, number of bytes per image frame (20x30x3).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on pi_strobe and pi_data (minimum 2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, number of idle pi_clk cycles in RECV before the frame is aborted.
REQ-004 pi_clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 pi_data  input  8  byte driven by the Raspberry Pi GPIO; asynchronous; stable from at least SYNC_STAGES+1 cycles before the pi_strobe rise until pi_strobe falls.
REQ-007 pi_strobe  input  1  asynchronous byte strobe from the Pi; one byte per rising edge.
REQ-008 rearm  input  1  synchronous one-cycle request from the consumer to accept a new frame.
REQ-009 gpio_pin  output  8  captured byte, held until the next capture.
REQ-010 write_enable  output  1  one-cycle pulse marking gpio_pin valid; feeds the image loader directly.
REQ-011 byte_count  output  11  bytes accepted in the current frame.
REQ-012 frame_done  output  1  one-cycle pulse when byte FRAME_BYTES is accepted.
REQ-013 busy  output  1  high in RECV.
REQ-014 overrun  output  1  sticky; a strobe edge arrived in DONE.
REQ-015 timeout_err  output  1  sticky; a frame was aborted by timeout.

Function
REQ-016 pi_strobe and pi_data SHALL each pass through a SYNC_STAGES flip-flop chain; a rising edge SHALL be detected as synced strobe high while its previous registered value is low.
REQ-017 On a detected edge in IDLE or RECV, gpio_pin SHALL load the synchronized pi_data, and write_enable SHALL pulse in the next cycle; latency from the pi_strobe rise to write_enable SHALL be SYNC_STAGES+1 cycles.
REQ-018 A strobe held high SHALL produce exactly one write_enable.
REQ-019 States SHALL be IDLE, RECV and DONE.
REQ-020 IDLE->RECV SHALL occur on the first edge, and that byte SHALL be accepted; byte_count SHALL become 1.
REQ-021 In RECV, each edge SHALL increment byte_count; the edge that makes byte_count equal FRAME_BYTES SHALL pulse frame_done in the same cycle as write_enable, and the state SHALL become DONE.
REQ-022 In DONE, edges SHALL be ignored: no write_enable, gpio_pin unchanged, overrun set to 1.
REQ-023 In DONE, rearm SHALL move the state to IDLE and clear byte_count, overrun and timeout_err; an edge in the same cycle SHALL be discarded.
REQ-024 rearm outside DONE SHALL have no effect.
REQ-025 byte_count SHALL saturate at FRAME_BYTES and never wrap.

Reset
REQ-026 With rst high at a clock edge, the next state SHALL be: state IDLE, gpio_pin 0, write_enable 0, byte_count 0, frame_done 0, busy 0, overrun 0, timeout_err 0, synchronizer chains 0, timeout counter 0.
REQ-027 rst mid-frame SHALL discard the partial frame.
REQ-028 A pi_strobe held high through reset release SHALL NOT generate an edge.

Configuration
REQ-029 With macro PI_RX_TIMEOUT_EN defined, a counter SHALL count cycles without an edge while in RECV.
REQ-030 With PI_RX_TIMEOUT_EN defined, the counter SHALL reset on each accepted edge; on reaching TIMEOUT_CYCLES the state SHALL return to IDLE, byte_count SHALL clear and timeout_err SHALL set.
REQ-031 With PI_RX_TIMEOUT_EN defined, an edge in the expiry cycle SHALL win: the byte is accepted and the counter restarts.
REQ-032 Without PI_RX_TIMEOUT_EN, the timeout logic SHALL be absent, RECV SHALL wait indefinitely, and timeout_err SHALL be tied to 0.

Verification
REQ-033 Bench SHALL cover: reset, then 1800 strobes of bytes 0..255 repeating -> 1800 write_enable pulses, gpio_pin matching each byte, frame_done exactly once with the 1800th pulse, state DONE, byte_count 1800.
REQ-034 Bench SHALL cover: single strobe rise with pi_data=0xA5 and SYNC_STAGES=2 -> write_enable exactly 3 cycles later, gpio_pin 0xA5; strobe held 50 cycles -> only one pulse.
REQ-035 Bench SHALL cover: in DONE, 3 extra strobes -> no write_enable, overrun 1; then rearm -> IDLE, overrun 0, byte_count 0; next strobe accepted with byte_count 1.
REQ-036 Bench SHALL cover: rst asserted after 700 bytes -> all outputs 0 next cycle; a new 1800-byte frame completes normally.
REQ-037 Bench SHALL cover: PI_RX_TIMEOUT_EN with TIMEOUT_CYCLES=100, 10 bytes then no strobes -> IDLE after 100 cycles, timeout_err 1, byte_count 0; without the macro -> stays RECV, byte_count 10.
REQ-038 Bench SHALL cover: rearm and a strobe edge in the same DONE cycle -> no write_enable, state IDLE.
